// File: rtl/divider_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
// The driver of operands uses master; the divider uses slave.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif

interface divider_seq_if #(
    parameter int n = `DEFAULT_WIDTH
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         div_zero;

    modport master (
        output in_valid, a, b, sign, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, a, b, sign, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divider_seq.sv
// Restoring shift-subtract divider, one quotient bit per cycle, signed/unsigned.
// Define DIVIDER_SEQ_FASTPATH_EN to finish |a|<|b| and |b|==1 in two cycles.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif

module divider_seq #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    divider_seq_if.slave  bus
);
    localparam int CW = $clog2(n+1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    state_reg;
    logic [n-1:0]  a_reg;
    logic [n-1:0]  b_reg;
    logic          sign_reg;
    logic [n-1:0]  dvd_reg;
    logic [n-1:0]  dvs_reg;
    logic [n-1:0]  rem_reg;
    logic [CW-1:0] cnt_reg;
    logic          qneg_reg;
    logic          rneg_reg;
    logic          dz_reg;
    logic [n-1:0]  quotient_reg;
    logic [n-1:0]  remainder_reg;
    logic          div_zero_reg;

    logic          a_neg;
    logic          b_neg;
    logic [n-1:0]  abs_a;
    logic [n-1:0]  abs_b;
    logic [n:0]    shifted;
    logic [n:0]    trial;

    assign a_neg = sign_reg & a_reg[n-1];
    assign b_neg = sign_reg & b_reg[n-1];
    assign abs_a = a_neg ? -a_reg : a_reg;
    assign abs_b = b_neg ? -b_reg : b_reg;

    // Partial remainder can exceed n bits after the shift, so the trial is n+1 wide.
    assign shifted = {rem_reg, dvd_reg[n-1]};
    assign trial   = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_reg      <= 1'b0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        sign_reg  <= bus.sign;
                        state_reg <= PREP;
                    end
                end
                PREP: begin
                    qneg_reg <= a_neg ^ b_neg;
                    rneg_reg <= a_neg;
                    dvd_reg  <= abs_a;
                    dvs_reg  <= abs_b;
                    rem_reg  <= '0;
                    cnt_reg  <= CW'(n-1);
                    dz_reg   <= 1'b0;
                    if (abs_b == '0) begin
                        dz_reg    <= 1'b1;
                        state_reg <= FIX;
`ifdef DIVIDER_SEQ_FASTPATH_EN
                    end else if (abs_a < abs_b) begin
                        dvd_reg   <= '0;
                        rem_reg   <= abs_a;
                        state_reg <= FIX;
                    end else if (abs_b == n'(1)) begin
                        state_reg <= FIX;
`endif
                    end else begin
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    if (!trial[n]) begin
                        rem_reg <= trial[n-1:0];
                        dvd_reg <= {dvd_reg[n-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[n-1:0];
                        dvd_reg <= {dvd_reg[n-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0)
                        state_reg <= FIX;
                end
                FIX: begin
                    // Divide-by-zero reports the raw dividend, bypassing the sign fix.
                    if (dz_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= a_reg;
                        div_zero_reg  <= 1'b1;
                    end else begin
                        quotient_reg  <= qneg_reg ? -dvd_reg : dvd_reg;
                        remainder_reg <= rneg_reg ? -rem_reg : rem_reg;
                        div_zero_reg  <= 1'b0;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divider_seq.sv
// Directed-vector bench for divider_seq (n=32): results, latency, backpressure,
// flush and asynchronous reset; fast-path latencies follow DIVIDER_SEQ_FASTPATH_EN.
`timescale 1ns/1ps

module tb_divider_seq;
    localparam int N = 32;
`ifdef DIVIDER_SEQ_FASTPATH_EN
    localparam int LF = 2;
`else
    localparam int LF = N + 2;
`endif
    localparam int LS = N + 2;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sign;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    divider_seq_if #(.n(N)) bus ();

    divider_seq #(.n(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one operation at a negedge and count edges from accept to out_valid.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_b,
                         input logic ts, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        bus.a = ta; bus.b = tb_b; bus.sign = ts; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic [N-1:0] hq, hr;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [N-1:0] hq, hr;

        vecs[0]  = '{32'd100,       32'd7,          1'b0, 32'd14,         32'd2,          1'b0, LS};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, LS};
        vecs[2]  = '{32'hFFFFFFF9,  32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, LS};
        vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, LF};
        vecs[4]  = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 2};
        vecs[5]  = '{32'd3,         32'd9,          1'b0, 32'd0,          32'd3,          1'b0, LF};
        vecs[6]  = '{32'hFFFFFFF7,  32'd1,          1'b1, 32'hFFFFFFF7,   32'd0,          1'b0, LF};
        vecs[7]  = '{32'hFFFFFFF9,  32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 2};
        vecs[8]  = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, LS};
        vecs[9]  = '{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, LF};
        vecs[10] = '{32'd100,       32'd100,        1'b0, 32'd1,          32'd0,          1'b0, LS};
        vecs[11] = '{32'h80000000,  32'h10,         1'b0, 32'h08000000,   32'd0,          1'b0, LS};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_quotient",  bus.quotient,  32'd0);
        chk("reset_remainder", bus.remainder, 32'd0);
        chk("reset_div_zero",  {31'd0, bus.div_zero},  32'd0);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sign, lat);
            $display("vec %0d: a=%h b=%h sign=%0b -> q=%h r=%h dz=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sign,
                     bus.quotient, bus.remainder, bus.div_zero, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_quotient", i), bus.quotient, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), bus.remainder, vecs[i].r);
            chk($sformatf("vec%0d_div_zero", i), {31'd0, bus.div_zero}, {31'd0, vecs[i].dz});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_in_ready_after", i), {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        end

        // Backpressure: hold the result for 10 cycles, then release.
        bus.out_ready = 1'b0;
        do_op(32'd1000, 32'd33, 1'b0, lat);
        $display("backpressure op: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        chk("bp_latency", lat, LS);
        hq = bus.quotient;
        hr = bus.remainder;
        chk("bp_quotient", hq, 32'd30);
        chk("bp_remainder", hr, 32'd10);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
            chk("bp_hold_quotient", bus.quotient, hq);
            chk("bp_hold_remainder", bus.remainder, hr);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        do_op(32'd50, 32'd6, 1'b0, lat);
        $display("post-bp op: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        chk("post_bp_latency", lat, LS);
        chk("post_bp_quotient", bus.quotient, 32'd8);
        chk("post_bp_remainder", bus.remainder, 32'd2);
        @(posedge clk);

        // flush together with in_valid in IDLE must not accept.
        @(negedge clk);
        bus.a = 32'd9; bus.b = 32'd4; bus.in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("flush in IDLE with in_valid: in_ready=%0b", bus.in_ready);

        // flush during ITER cycle 5: no result, back to IDLE, outputs unchanged.
        @(negedge clk);
        bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_iter_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            chk("flush_no_out_valid", seen, 32'd0);
        end
        chk("flush_quotient_held", bus.quotient, 32'd8);
        $display("flush mid-ITER: out_valid stayed low, q=%h", bus.quotient);

        // Asynchronous reset in the middle of ITER.
        @(negedge clk);
        bus.a = 32'd77; bus.b = 32'd5; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_quotient", bus.quotient, 32'd0);
        chk("async_rst_remainder", bus.remainder, 32'd0);
        chk("async_rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        $display("async reset mid-ITER: q=%h r=%h out_valid=%0b", bus.quotient, bus.remainder, bus.out_valid);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(32'd77, 32'd5, 1'b0, lat);
        $display("post-reset op: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        chk("post_rst_latency", lat, LS);
        chk("post_rst_quotient", bus.quotient, 32'd15);
        chk("post_rst_remainder", bus.remainder, 32'd2);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Multi-cycle iterative divider that replaces the combinational array divider wherever timing or area cannot afford n cascaded subtractors. It uses a restoring shift-subtract algorithm and produces one quotient bit per cycle. It takes operands through a valid/ready handshake and returns quotient and remainder through a second valid/ready handshake, so the execute stage can stall on it. It handles signed/unsigned operands, divide-by-zero and a pipeline flush.

Parameters:
n, `DEFAULT_WIDTH, operand/result width in bits (n >= 2)
CW, $clog2(n+1), iteration counter width (derived; not to be overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any operation in flight
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  n  dividend
b  input  n  divisor
sign  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result present
out_ready  input  1  consumer takes result
quotient  output  n  quotient, truncated toward zero
remainder  output  n  remainder; sign follows dividend
div_zero  output  1  result produced with b == 0 (valid with out_valid)

Behaviour:
- Reset (reset_n low, async): state=IDLE; in_ready=1 after deassertion; out_valid=0; quotient, remainder, div_zero=0; counter=0.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: in_ready=1. in_valid&in_ready latches a, b, sign. Go to PREP.
- PREP (1 cycle), computing from the latched operands:
  - as=sign&a[n-1], bs=sign&b[n-1]; record qneg=as^bs and rneg=as.
  - Load |a| into the shift register and |b| into the divisor register; partial remainder=0; counter=n-1.
  - If |b|==0: set div_zero and go to FIX with quotient=all ones and remainder=a raw (no negation), overriding the sign fix.
- ITER (n cycles, one per counter value n-1..0):
  - Shift the {rem, dividend} pair left 1.
  - Trial t = rem - divisor, computed n+1 bits wide.
  - If t >= 0: rem=t and quotient bit=1; else rem is unchanged and the bit=0.
  - Leave ITER after the cycle with counter==0.
- FIX (1 cycle): quotient = qneg ? -q : q; remainder = rneg ? -r : r, both mod 2^n.
  - Signed overflow (a=-2^(n-1), b=-1) yields quotient=-2^(n-1), remainder=0, with no special casing.
- DONE: out_valid=1 and outputs held stable until out_ready. out_valid&out_ready returns to IDLE; in_ready rises the following cycle. There is no same-cycle accept of the next operation.
- Latency: accept edge to out_valid = n+2 cycles (PREP + n ITER + FIX). Divide-by-zero takes 2 cycles (PREP, FIX).
- in_ready=0 in every state except IDLE. a, b and sign are don't-care outside the accept cycle.
- flush: in any state, state goes to IDLE on the next edge and out_valid drops; the partial result is discarded.
  - flush together with in_valid in IDLE: the operation is not accepted.
  - flush takes priority over out_ready.
- reset_n asserted mid-operation: immediate return to reset values. No result is produced.
- quotient, remainder and div_zero are registered. They change only on entry to DONE or on reset.

Optional Feature:
DIVIDER_SEQ_FASTPATH_EN
- Defined: PREP checks two extra cases.
  - |a| < |b|: go straight to FIX with q=0, r=|a|, so remainder follows the sign rule and equals a. Latency 2.
  - |b|==1: go straight to FIX with q=|a|, r=0. Latency 2.
- Undefined: these cases take the full n+2 cycles. Results are identical in both builds; only latency differs.

Test Plan:
- n=32, unsigned a=100, b=7, out_ready=1 -> out_valid exactly 34 cycles after accept; quotient=14, remainder=2, div_zero=0; in_ready=1 the cycle after the handshake.
- Signed a=-7 (0xFFFFFFF9), b=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); same operands with sign=0 -> quotient=0x7FFFFFFC, remainder=1.
- Signed a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0. Then a=5, b=0 -> div_zero=1, quotient=0xFFFFFFFF, remainder=5, latency 2.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. out_ready=1 -> IDLE, and a new operation is accepted the following cycle.
- flush asserted at ITER cycle 5 -> out_valid never rises, in_ready=1 next cycle. reset_n pulsed low mid-ITER -> all outputs 0 asynchronously.
- With DIVIDER_SEQ_FASTPATH_EN: a=3, b=9 -> quotient=0, remainder=3, latency 2; a=-9, b=1 signed -> quotient=-9, latency 2. Without the macro the same cases take latency 34 with identical results.
